alu_exec_ctrl: RTL and testbench

//  Execute-stage initiator for the Process/ALU datapath. Accepts one decoded op per handshake
//  and drives alu_op/a_data/b_data/bit_location/psw_in. Captures ans/psw_out and commits the

---
 rtl/alu_exec_ctrl.sv | 148 ++++++++++++++
 tb/tb_alu_exec_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller: issues decoded ops to the Process ALU and commits results to ACC/B/PSW/write-back.
// MUL AB is executed locally as an 8-step shift-add because Process returns zero for that code.
module alu_exec_ctrl #(
    parameter logic [3:0] MUL_OP  = 4'hf,
    parameter int         MUL_CYC = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic [3:0] op_code,
    input  logic [7:0] src_a,
    input  logic [7:0] src_b,
    input  logic [2:0] bit_loc,
    input  logic [1:0] dst_sel,
    output logic [3:0] alu_op,
    output logic [7:0] a_data,
    output logic [7:0] b_data,
    output logic [2:0] bit_location,
    output logic [7:0] psw_in,
    input  logic [7:0] ans,
    input  logic [7:0] psw_out,
    output logic [7:0] acc,
    output logic [7:0] b_reg,
    output logic [7:0] psw,
    output logic       wb_valid,
    output logic [7:0] wb_data,
    input  logic       wb_ready,
    output logic       done
);
    localparam int CW = (MUL_CYC > 1) ? $clog2(MUL_CYC) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, MUL, WB} state_t;

    state_t        state_q;
    logic [3:0]    alu_op_q;
    logic [7:0]    a_q, b_q, acc_q, b_reg_q, psw_q, wb_data_q;
    logic [2:0]    bit_q;
    logic [1:0]    dst_q;
    logic          wb_valid_q, done_q;
    logic [15:0]   mcand_q, prod_q;
    logic [7:0]    mplier_q;
    logic [CW-1:0] cnt_q;

    logic [7:0]    acc_d;
    logic [15:0]   prod_d;
    logic          mul_last;
    logic          unused_psw_p;

    // P is recomputed locally from ACC, so the ALU's parity bit is never used
    assign unused_psw_p = psw_out[0];

    assign acc_d    = (dst_q == 2'b00) ? ans : acc_q;
    assign prod_d   = prod_q + (mplier_q[0] ? mcand_q : 16'h0000);
    assign mul_last = (cnt_q == CW'(MUL_CYC - 1));

    assign op_ready     = (state_q == IDLE);
    assign alu_op       = alu_op_q;
    assign a_data       = a_q;
    assign b_data       = b_q;
    assign bit_location = bit_q;
    assign psw_in       = psw_q;
    assign acc          = acc_q;
    assign b_reg        = b_reg_q;
    assign psw          = psw_q;
    assign wb_valid     = wb_valid_q;
    assign wb_data      = wb_data_q;
    assign done         = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            alu_op_q   <= '0;
            a_q        <= '0;
            b_q        <= '0;
            bit_q      <= '0;
            dst_q      <= '0;
            acc_q      <= '0;
            b_reg_q    <= '0;
            psw_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            done_q     <= 1'b0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            prod_q     <= '0;
            cnt_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (op_valid) begin
                    alu_op_q <= op_code;
                    a_q      <= src_a;
                    b_q      <= src_b;
                    bit_q    <= bit_loc;
                    dst_q    <= dst_sel;
                    if (op_code == MUL_OP) begin
                        mcand_q  <= {8'h00, src_a};
                        mplier_q <= src_b;
                        prod_q   <= '0;
                        cnt_q    <= '0;
                        state_q  <= MUL;
                    end else begin
                        state_q  <= EXEC;
                    end
                end
                EXEC: begin
                    psw_q <= {psw_out[7:1], ^acc_d};
                    case (dst_q)
                        2'b00: acc_q <= ans;
                        2'b01: b_reg_q <= ans;
                        2'b11: begin
                            wb_valid_q <= 1'b1;
                            wb_data_q  <= ans;
                        end
                        default: ;
                    endcase
                    if (dst_q == 2'b11) begin
                        state_q <= WB;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                MUL: begin
                    prod_q   <= prod_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    // last partial product is folded straight into the commit
                    if (mul_last) begin
                        acc_q   <= prod_d[7:0];
                        b_reg_q <= prod_d[15:8];
                        psw_q   <= {1'b0, psw_q[6:3], |prod_d[15:8], psw_q[1], ^prod_d[7:0]};
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                WB: if (wb_ready) begin
                    wb_valid_q <= 1'b0;
                    done_q     <= 1'b1;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl: stub ALU driven from the bench, outputs sampled on the falling edge.
module tb_alu_exec_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       op_valid = 1'b0;
    logic       op_ready;
    logic [3:0] op_code = '0;
    logic [7:0] src_a = '0, src_b = '0;
    logic [2:0] bit_loc = '0;
    logic [1:0] dst_sel = '0;
    logic [3:0] alu_op;
    logic [7:0] a_data, b_data, psw_in;
    logic [2:0] bit_location;
    logic [7:0] ans = '0, psw_out = '0;
    logic [7:0] acc, b_reg, psw, wb_data;
    logic       wb_valid, done;
    logic       wb_ready = 1'b0;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_exec_ctrl dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .src_a(src_a), .src_b(src_b), .bit_loc(bit_loc), .dst_sel(dst_sel),
        .alu_op(alu_op), .a_data(a_data), .b_data(b_data), .bit_location(bit_location),
        .psw_in(psw_in), .ans(ans), .psw_out(psw_out), .acc(acc), .b_reg(b_reg), .psw(psw),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_ready(wb_ready), .done(done)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // present one op at the falling edge; the next rising edge is the accept edge
    task automatic present(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] bl, input logic [1:0] d);
        op_valid = 1'b1; op_code = c; src_a = a; src_b = b; bit_loc = bl; dst_sel = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("rst_acc", acc, 8'h00);
        chk("rst_b", b_reg, 8'h00);
        chk("rst_psw", psw, 8'h00);
        chk("rst_aluop", alu_op, 4'h0);
        chk("rst_adata", a_data, 8'h00);
        chk("rst_wbv", wb_valid, 1'b0);
        chk("rst_done", done, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", op_ready, 1'b1);

        // ALU op to ACC: commit on the 2nd edge counting the accept edge
        ans = 8'h80; psw_out = 8'hC4;
        present(4'h2, 8'h11, 8'h22, 3'd5, 2'b00);
        tick();
        op_valid = 1'b0;
        chk("alu_ready_exec", op_ready, 1'b0);
        chk("alu_acc_early", acc, 8'h00);
        chk("alu_done_early", done, 1'b0);
        chk("alu_op_out", alu_op, 4'h2);
        chk("alu_a_out", a_data, 8'h11);
        chk("alu_b_out", b_data, 8'h22);
        chk("alu_bit_out", bit_location, 3'd5);
        chk("alu_pswin", psw_in, 8'h00);
        tick();
        chk("alu_acc", acc, 8'h80);
        chk("alu_psw", psw, 8'hC5);
        chk("alu_done", done, 1'b1);
        chk("alu_ready_back", op_ready, 1'b1);
        tick();
        chk("alu_done_once", done, 1'b0);

        // MUL 50*A0 from clean PSW
        do_reset();
        present(4'hF, 8'h50, 8'hA0, 3'd0, 2'b11);
        tick();
        op_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("mul_busy%0d", i), op_ready, 1'b0);
            chk($sformatf("mul_nodone%0d", i), done, 1'b0);
            tick();
        end
        chk("mul1_acc", acc, 8'h00);
        chk("mul1_b", b_reg, 8'h32);
        chk("mul1_psw", psw, 8'h04);
        chk("mul1_done", done, 1'b1);
        chk("mul1_nowb", wb_valid, 1'b0);

        // PSW-only op loads F8 (ACC=00 so P=0)
        ans = 8'h77; psw_out = 8'hF8;
        present(4'h3, 8'h00, 8'h00, 3'd0, 2'b10);
        tick();
        op_valid = 1'b0;
        tick();
        chk("pswonly_psw", psw, 8'hF8);
        chk("pswonly_acc", acc, 8'h00);
        chk("pswonly_b", b_reg, 8'h32);

        // MUL 0F*03 with PSW=F8
        present(4'hF, 8'h0F, 8'h03, 3'd0, 2'b00);
        tick();
        op_valid = 1'b0;
        repeat (8) tick();
        chk("mul2_acc", acc, 8'h2D);
        chk("mul2_b", b_reg, 8'h00);
        chk("mul2_psw", psw, 8'h78);
        chk("mul2_done", done, 1'b1);

        // external write-back with sink stalled 3 cycles
        ans = 8'h5A; psw_out = 8'h00;
        present(4'h4, 8'h01, 8'h02, 3'd0, 2'b11);
        tick();
        op_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wb_valid%0d", i), wb_valid, 1'b1);
            chk($sformatf("wb_data%0d", i), wb_data, 8'h5A);
            chk($sformatf("wb_nodone%0d", i), done, 1'b0);
            if (i < 3) tick();
        end
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        chk("wb_drop", wb_valid, 1'b0);
        chk("wb_done", done, 1'b1);
        chk("wb_acc", acc, 8'h2D);
        chk("wb_psw", psw, 8'h00);
        chk("wb_ready_back", op_ready, 1'b1);

        // two queued ops with op_valid held high
        ans = 8'h33; psw_out = 8'h00;
        present(4'h5, 8'hA1, 8'hB1, 3'd1, 2'b00);
        tick();
        chk("q1_a", a_data, 8'hA1);
        chk("q1_ready", op_ready, 1'b0);
        present(4'h6, 8'hA2, 8'hB2, 3'd2, 2'b01);
        tick();
        chk("q1_acc", acc, 8'h33);
        chk("q1_done", done, 1'b1);
        chk("q1_hold_a", a_data, 8'hA1);
        chk("q1_hold_op", alu_op, 4'h5);
        chk("q2_ready", op_ready, 1'b1);
        tick();
        op_valid = 1'b0;
        chk("q2_a", a_data, 8'hA2);
        chk("q2_b", b_data, 8'hB2);
        chk("q2_op", alu_op, 4'h6);
        chk("q2_bit", bit_location, 3'd2);
        tick();
        chk("q2_breg", b_reg, 8'h33);
        chk("q2_acc", acc, 8'h33);
        chk("q2_done", done, 1'b1);

        // reset during MUL cycle 4 aborts without commit
        present(4'hF, 8'h0F, 8'h03, 3'd0, 2'b00);
        tick();
        op_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("abort_acc", acc, 8'h00);
        chk("abort_b", b_reg, 8'h00);
        chk("abort_psw", psw, 8'h00);
        chk("abort_done", done, 1'b0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (8) begin
            tick();
            chk("abort_nodone", done, 1'b0);
        end
        chk("abort_b_late", b_reg, 8'h00);

        ans = 8'h80; psw_out = 8'hC4;
        present(4'h2, 8'h11, 8'h22, 3'd0, 2'b00);
        tick();
        op_valid = 1'b0;
        tick();
        chk("post_acc", acc, 8'h80);
        chk("post_psw", psw, 8'hC5);
        chk("post_done", done, 1'b1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
